// File: rtl/oven_sequencer.sv
// Bake sequencer: IDLE -> PREHEAT -> READY -> COOK -> DONE, 1 s cook tick and seconds countdown,
// bang-bang heater with hysteresis. Optional pause in COOK when OVEN_SEQ_PAUSE_EN is defined.
module oven_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int TEMP_W   = 10,
    parameter int HYST     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cancel,
    input  logic [TEMP_W-1:0] goal_temp,
    input  logic [TEMP_W-1:0] cur_temp,
    input  logic [11:0]       cook_sec,
    output logic              heater_on,
    output logic [2:0]        state,
    output logic [11:0]       remaining,
    output logic              preheat_done,
    output logic              cook_done,
    output logic              alarm
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [11:0]       SEC_MAX   = 12'd3599;
    localparam logic [TEMP_W:0]   TEMP_MAX  = {1'b0, {TEMP_W{1'b1}}};
    localparam logic [TEMP_W:0]   HYST_X    = (TEMP_W + 1)'(HYST);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREHEAT = 3'd1,
        READY   = 3'd2,
        COOK    = 3'd3,
        DONE    = 3'd4,
        PAUSE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, cancel_q;
    logic               heater_q, heater_d;
    logic [11:0]        remaining_q, remaining_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               alarm_q, alarm_d;
    logic               preheat_done_q, cook_done_q;

    logic               st_e, cx_e;
    logic [TEMP_W:0]    goal_x, cur_x, lo_x, hi_x, hi_raw;

    assign st_e = start & ~start_q;
    assign cx_e = cancel & ~cancel_q;

    // Thresholds are evaluated one bit wider so the saturation points can be detected.
    assign goal_x = {1'b0, goal_temp};
    assign cur_x  = {1'b0, cur_temp};
    assign lo_x   = (goal_x >= HYST_X) ? (goal_x - HYST_X) : '0;
    assign hi_raw = goal_x + HYST_X;
    assign hi_x   = (hi_raw > TEMP_MAX) ? TEMP_MAX : hi_raw;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tick_d      = tick_q;
        heater_d    = heater_q;
        alarm_d     = 1'b0;

        if (cx_e) begin
            state_d     = IDLE;
            remaining_d = '0;
            tick_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (st_e && (cook_sec != 12'd0)) begin
                        state_d     = PREHEAT;
                        remaining_d = (cook_sec > SEC_MAX) ? SEC_MAX : cook_sec;
                    end
                end
                PREHEAT: begin
                    if (cur_x >= lo_x) state_d = READY;
                end
                READY: begin
                    if (st_e) begin
                        state_d = COOK;
                        tick_d  = '0;
                    end
                end
                COOK: begin
`ifdef OVEN_SEQ_PAUSE_EN
                    if (st_e) begin
                        state_d = PAUSE;
                    end else
`endif
                    if (tick_q == TICK_LAST) begin
                        tick_d      = '0;
                        remaining_d = remaining_q - 12'd1;
                        if (remaining_q == 12'd1) begin
                            state_d = DONE;
                            alarm_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef OVEN_SEQ_PAUSE_EN
                PAUSE: begin
                    if (st_e) state_d = COOK;
                end
`endif
                DONE: begin
                    if (st_e) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Heater follows the state being entered so it never lags a return to IDLE/DONE.
        if (state_d == IDLE || state_d == DONE) begin
            heater_d = 1'b0;
        end else if (cur_x < lo_x) begin
            heater_d = 1'b1;
        end else if (cur_x >= hi_x) begin
            heater_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            start_q        <= 1'b0;
            cancel_q       <= 1'b0;
            heater_q       <= 1'b0;
            remaining_q    <= '0;
            tick_q         <= '0;
            alarm_q        <= 1'b0;
            preheat_done_q <= 1'b0;
            cook_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            cancel_q       <= cancel;
            heater_q       <= heater_d;
            remaining_q    <= remaining_d;
            tick_q         <= tick_d;
            alarm_q        <= alarm_d;
            preheat_done_q <= (state_d == READY) || (state_d == COOK) || (state_d == PAUSE);
            cook_done_q    <= (state_d == DONE);
        end
    end

    assign state        = state_q;
    assign heater_on    = heater_q;
    assign remaining    = remaining_q;
    assign preheat_done = preheat_done_q;
    assign cook_done    = cook_done_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_oven_sequencer.sv
// Randomized + directed bench for oven_sequencer: a behavioural model queues the expected outputs
// each cycle and a monitor pops and compares them on the falling edge.
module tb_oven_sequencer;
    localparam int TICK_DIV = 4;
    localparam int TEMP_W   = 10;
    localparam int HYST     = 2;
    localparam int TMAX     = 1023;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, cancel;
    logic [TEMP_W-1:0] goal_temp, cur_temp;
    logic [11:0]       cook_sec;
    logic              heater_on, preheat_done, cook_done, alarm;
    logic [2:0]        state;
    logic [11:0]       remaining;

    oven_sequencer #(.TICK_DIV(TICK_DIV), .TEMP_W(TEMP_W), .HYST(HYST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
        .goal_temp(goal_temp), .cur_temp(cur_temp), .cook_sec(cook_sec),
        .heater_on(heater_on), .state(state), .remaining(remaining),
        .preheat_done(preheat_done), .cook_done(cook_done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        heat;
        logic [11:0] rem;
        logic        pre;
        logic        cd;
        logic        al;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp, mon_act;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Behavioural model: phase number, seconds left, cycles spent cooking in this bake.
    int m_state, m_rem, m_elapsed, m_heat, m_alarm, m_prev_start, m_prev_cancel;

    function automatic void model_reset();
        m_state = 0; m_rem = 0; m_elapsed = 0; m_heat = 0; m_alarm = 0;
        m_prev_start = 0; m_prev_cancel = 0;
    endfunction

    function automatic void model_step();
        int se, ce, lo, hi, ns, cur, goal;
        se   = (start && !m_prev_start) ? 1 : 0;
        ce   = (cancel && !m_prev_cancel) ? 1 : 0;
        cur  = int'(cur_temp);
        goal = int'(goal_temp);
        lo   = (goal - HYST < 0) ? 0 : goal - HYST;
        hi   = (goal + HYST > TMAX) ? TMAX : goal + HYST;
        ns   = m_state;
        m_alarm = 0;
        if (ce != 0) begin
            ns = 0; m_rem = 0; m_elapsed = 0;
        end else begin
            case (m_state)
                0: if (se != 0 && cook_sec != 0) begin
                       ns = 1;
                       m_rem = (int'(cook_sec) > 3599) ? 3599 : int'(cook_sec);
                   end
                1: if (cur >= lo) ns = 2;
                2: if (se != 0) begin ns = 3; m_elapsed = 0; end
                3: begin
`ifdef OVEN_SEQ_PAUSE_EN
                       if (se != 0) ns = 5;
                       else
`endif
                       begin
                           m_elapsed++;
                           if (m_elapsed % TICK_DIV == 0) begin
                               m_rem--;
                               if (m_rem == 0) begin ns = 4; m_alarm = 1; end
                           end
                       end
                   end
                5: if (se != 0) ns = 3;
                4: if (se != 0) ns = 0;
                default: ns = 0;
            endcase
        end
        if (ns == 0 || ns == 4) m_heat = 0;
        else if (cur < lo) m_heat = 1;
        else if (cur >= hi) m_heat = 0;
        m_state = ns;
        m_prev_start = start ? 1 : 0;
        m_prev_cancel = cancel ? 1 : 0;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st   = 3'(m_state);
        o.heat = (m_heat != 0);
        o.rem  = 12'(m_rem);
        o.pre  = (m_state == 2 || m_state == 3 || m_state == 5);
        o.cd   = (m_state == 4);
        o.al   = (m_alarm != 0);
        return o;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle();
        start = 1'b0; cycle();
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; cycle();
        cancel = 1'b0; cycle();
    endtask

    task automatic to_cook(input int goal, input int secs);
        goal_temp = TEMP_W'(goal); cur_temp = TEMP_W'(goal); cook_sec = 12'(secs);
        pulse_start();
        run(2);
        pulse_start();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {state, heater_on, remaining, preheat_done, cook_done, alarm};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL outputs cyc=%0d: got st=%0d heat=%b rem=%0d pre=%b cd=%b al=%b, want st=%0d heat=%b rem=%0d pre=%b cd=%b al=%b",
                         cyc, mon_act.st, mon_act.heat, mon_act.rem, mon_act.pre, mon_act.cd, mon_act.al,
                         mon_exp.st, mon_exp.heat, mon_exp.rem, mon_exp.pre, mon_exp.cd, mon_exp.al);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget, r, c;
        model_reset();
        rst_n = 1'b0; start = 1'b1; cancel = 1'b0;
        goal_temp = 10'd300; cur_temp = 10'd60; cook_sec = 12'd0;

        $display("scenario: reset held with start high");
        run(3);
        #2 rst_n = 1'b1;
        run(3);

        $display("scenario: full bake 300 deg, 3 s");
        start = 1'b0; cook_sec = 12'd3; cycle();
        start = 1'b1; cycle();
        start = 1'b0;
        while (cur_temp < 10'd298) begin
            cur_temp = (cur_temp + 10'd40 > 10'd298) ? 10'd298 : cur_temp + 10'd40;
            cycle();
        end
        run(2);
        pulse_start();
        run(14);
        pulse_start();

        $display("scenario: hysteresis in COOK");
        to_cook(300, 20);
        cur_temp = 10'd297; cycle();
        cur_temp = 10'd299; cycle();
        cur_temp = 10'd302; cycle();
        cur_temp = 10'd299; cycle();
        cur_temp = 10'd297; cycle();
        pulse_cancel();

        $display("scenario: boundaries");
        cook_sec = 12'd0; pulse_start(); run(2);
        goal_temp = 10'd1; cur_temp = 10'd0; cook_sec = 12'd2;
        pulse_start(); run(2); pulse_cancel();
        goal_temp = 10'd1023; cur_temp = 10'd1020; cook_sec = 12'd4000;
        pulse_start();
        cur_temp = 10'd1022; cycle();
        cur_temp = 10'd1023; run(2);
        pulse_cancel();

        $display("scenario: start and cancel together in READY");
        goal_temp = 10'd300; cur_temp = 10'd300; cook_sec = 12'd3;
        pulse_start(); run(2);
        start = 1'b1; cancel = 1'b1; cycle();
        start = 1'b0; cancel = 1'b0; run(2);

        $display("scenario: cancel on the expiry tick");
        to_cook(300, 2);
        budget = 0;
        while (!(m_state == 3 && m_rem == 1 && (m_elapsed + 1) % TICK_DIV == 0) && budget < 100) begin
            cycle(); budget++;
        end
        n_cmp++;
        if (budget >= 100) begin
            n_err++;
            $display("FAIL expiry_wait: waited %0d cycles, required < 100", budget);
        end
        pulse_cancel();

        $display("scenario: reset mid-cook");
        to_cook(300, 5);
        run(3);
        #2 rst_n = 1'b0;
        run(2);
        #2 rst_n = 1'b1;
        run(2);

`ifdef OVEN_SEQ_PAUSE_EN
        $display("scenario: pause and resume");
        to_cook(300, 5);
        budget = 0;
        while (m_rem != 2 && budget < 100) begin cycle(); budget++; end
        start = 1'b1; cycle(); start = 1'b0;
        run(20);
        pulse_start();
        run(12);
        pulse_start();
`endif

        $display("scenario: randomized traffic");
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) start = ~start;
            cancel = ($urandom_range(0, 199) == 0);
            if (m_state == 0 && r >= 90) begin
                c = int'($urandom_range(0, 7));
                case (c)
                    0: goal_temp = 10'd0;
                    1: goal_temp = 10'd1;
                    2: goal_temp = 10'd1022;
                    3: goal_temp = 10'd1023;
                    default: goal_temp = TEMP_W'($urandom_range(0, 1023));
                endcase
                c = int'($urandom_range(0, 9));
                cook_sec = (c == 0) ? 12'($urandom_range(3590, 4095)) : 12'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 3) == 0) begin
                cur_temp = TEMP_W'($urandom_range(0, 1023));
            end else begin
                c = int'(goal_temp) + int'($urandom_range(0, 8)) - 4;
                cur_temp = TEMP_W'((c < 0) ? 0 : ((c > TMAX) ? TMAX : c));
            end
            if (r == 50 && $urandom_range(0, 9) == 0) begin
                #2 rst_n = 1'b0;
                cycle();
                #2 rst_n = 1'b1;
            end
            cycle();
        end

        start = 1'b0; cancel = 1'b0;
        run(2);
        @(posedge clk); @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
